// File: rtl/layer_tile_scheduler.sv
// Walks one CNN layer as filter-group (outer) x channel-chunk (inner) passes,
// issuing weight-load, compute and write-back commands with registered outputs.
module layer_tile_scheduler #(
    parameter int FILT_PER_PASS = 16,
    parameter int CH_PER_PASS   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_layer,
    input  logic [10:0] ifm_channel,
    input  logic [10:0] num_filter,
    input  logic [1:0]  kernel_size,
    output logic        wgt_load_start,
    input  logic        wgt_load_done,
    output logic        compute_start,
    input  logic        compute_done,
    output logic        wb_start,
    input  logic        wb_done,
    output logic [10:0] filter_base,
    output logic [10:0] channel_base,
    output logic [4:0]  filt_valid,
    output logic [4:0]  ch_valid,
    output logic        acc_clear,
    output logic        last_chunk,
    output logic [1:0]  kernel_size_q,
    output logic        busy,
    output logic        done_layer,
    output logic [2:0]  dbg_state
);
    // Command handshake: each *_start is a one-cycle pulse issued on entry to
    // a WAIT state; the matching *_done is honoured only while in that WAIT
    // state and is otherwise dropped, never queued.
    typedef enum logic [2:0] {
        IDLE, LOAD_W, WAIT_W, COMP, WAIT_C, WB, WAIT_WB, FIN
    } state_t;

    localparam logic [11:0] FPP = 12'(FILT_PER_PASS);
    localparam logic [11:0] CPP = 12'(CH_PER_PASS);

    state_t      state, next_state;
    logic [10:0] num_filter_q, ifm_channel_q;
    logic [10:0] num_filter_n, ifm_channel_n, filter_base_n, channel_base_n;
    logic [1:0]  kernel_size_n;
    logic        last_c, last_g;

    logic        wgt_load_start_d, compute_start_d, wb_start_d, acc_clear_d;
    logic        busy_d, done_d, last_chunk_d;
    logic [11:0] fdiff, cdiff;
    logic [4:0]  filt_valid_d, ch_valid_d;

    assign dbg_state = state;
    assign last_c = ({1'b0, channel_base} + CPP) >= {1'b0, ifm_channel_q};
    assign last_g = ({1'b0, filter_base} + FPP) >= {1'b0, num_filter_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            num_filter_q   <= '0;
            ifm_channel_q  <= '0;
            kernel_size_q  <= '0;
            filter_base    <= '0;
            channel_base   <= '0;
            filt_valid     <= '0;
            ch_valid       <= '0;
            last_chunk     <= 1'b0;
            wgt_load_start <= 1'b0;
            compute_start  <= 1'b0;
            wb_start       <= 1'b0;
            acc_clear      <= 1'b0;
            busy           <= 1'b0;
            done_layer     <= 1'b0;
        end else begin
            state          <= next_state;
            num_filter_q   <= num_filter_n;
            ifm_channel_q  <= ifm_channel_n;
            kernel_size_q  <= kernel_size_n;
            filter_base    <= filter_base_n;
            channel_base   <= channel_base_n;
            wgt_load_start <= wgt_load_start_d;
            compute_start  <= compute_start_d;
            wb_start       <= wb_start_d;
            acc_clear      <= acc_clear_d;
            busy           <= busy_d;
            done_layer     <= done_d;
            // Pass descriptors hold their last value once the layer is over.
            if (next_state != IDLE) begin
                filt_valid <= filt_valid_d;
                ch_valid   <= ch_valid_d;
                last_chunk <= last_chunk_d;
            end
        end
    end

    always_comb begin
        next_state     = state;
        num_filter_n   = num_filter_q;
        ifm_channel_n  = ifm_channel_q;
        kernel_size_n  = kernel_size_q;
        filter_base_n  = filter_base;
        channel_base_n = channel_base;
        case (state)
            IDLE: begin
                if (start_layer) begin
                    num_filter_n   = num_filter;
                    ifm_channel_n  = ifm_channel;
                    kernel_size_n  = kernel_size;
                    filter_base_n  = '0;
                    channel_base_n = '0;
                    next_state = (num_filter == '0 || ifm_channel == '0) ? FIN : LOAD_W;
                end
            end
            LOAD_W: next_state = WAIT_W;
            WAIT_W: if (wgt_load_done) next_state = COMP;
            COMP:   next_state = WAIT_C;
            WAIT_C: begin
                if (compute_done) begin
                    if (last_c) begin
                        next_state = WB;
                    end else begin
                        channel_base_n = channel_base + 11'(CH_PER_PASS);
                        next_state     = LOAD_W;
                    end
                end
            end
            WB:     next_state = WAIT_WB;
            WAIT_WB: begin
                if (wb_done) begin
                    if (last_g) begin
                        next_state = FIN;
                    end else begin
                        filter_base_n  = filter_base + 11'(FILT_PER_PASS);
                        channel_base_n = '0;
                        next_state     = LOAD_W;
                    end
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, so each
    // pulse lines up with the cycle its state is occupied.
    always_comb begin
        wgt_load_start_d = (next_state == LOAD_W);
        compute_start_d  = (next_state == COMP);
        acc_clear_d      = (next_state == COMP) && (channel_base_n == '0);
        wb_start_d       = (next_state == WB);
        busy_d           = (next_state != IDLE);
        // Zero-count layers reach FIN straight from IDLE and pulse one cycle later.
        done_d = ((state == WAIT_WB) && (next_state == FIN)) ||
                 ((state == FIN) && !done_layer);
        fdiff = {1'b0, num_filter_n} - {1'b0, filter_base_n};
        cdiff = {1'b0, ifm_channel_n} - {1'b0, channel_base_n};
        filt_valid_d = (fdiff >= FPP) ? FPP[4:0] : fdiff[4:0];
        ch_valid_d   = (cdiff >= CPP) ? CPP[4:0] : cdiff[4:0];
        last_chunk_d = ({1'b0, channel_base_n} + CPP) >= {1'b0, ifm_channel_n};
    end

endmodule

// File: tb/tb_layer_tile_scheduler.sv
// Directed bench for layer_tile_scheduler: an event-list model of each layer
// is checked pulse by pulse, plus latency and count literals per scenario.
module tb_layer_tile_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_layer;
    logic [10:0] ifm_channel, num_filter;
    logic [1:0]  kernel_size;
    logic        wgt_load_start, wgt_load_done;
    logic        compute_start, compute_done;
    logic        wb_start, wb_done;
    logic [10:0] filter_base, channel_base;
    logic [4:0]  filt_valid, ch_valid;
    logic        acc_clear, last_chunk, busy, done_layer;
    logic [1:0]  kernel_size_q;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    layer_tile_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start_layer(start_layer),
        .ifm_channel(ifm_channel), .num_filter(num_filter), .kernel_size(kernel_size),
        .wgt_load_start(wgt_load_start), .wgt_load_done(wgt_load_done),
        .compute_start(compute_start), .compute_done(compute_done),
        .wb_start(wb_start), .wb_done(wb_done),
        .filter_base(filter_base), .channel_base(channel_base),
        .filt_valid(filt_valid), .ch_valid(ch_valid),
        .acc_clear(acc_clear), .last_chunk(last_chunk),
        .kernel_size_q(kernel_size_q), .busy(busy), .done_layer(done_layer),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Event word: kind(2) filter_base(11) channel_base(11) filt_valid(5) ch_valid(5) last(1) acc(1)
    function automatic logic [35:0] ev(input int kind, input int fb, input int cb,
                                       input int fv, input int cv, input int lst, input int acc);
        ev = {2'(kind), 11'(fb), 11'(cb), 5'(fv), 5'(cv), 1'(lst), 1'(acc)};
    endfunction

    logic [35:0] exp_q[$];

    // Requests from the stimulus process; the monitor owns exp_q.
    int req_id = 0, built_id = 0, req_nf = 0, req_ic = 0;
    int rsp_lat = 1, inj_req = 0;

    task automatic build_model(input int nf, input int ic);
        int ng, nc, fb, cb, fv, cv;
        exp_q.delete();
        if (nf > 0 && ic > 0) begin
            ng = (nf + 15) / 16;
            nc = (ic + 15) / 16;
            for (int g = 0; g < ng; g++) begin
                for (int c = 0; c < nc; c++) begin
                    fb = g * 16;
                    cb = c * 16;
                    fv = (nf - fb < 16) ? nf - fb : 16;
                    cv = (ic - cb < 16) ? ic - cb : 16;
                    exp_q.push_back(ev(0, fb, cb, fv, cv, int'(c == nc - 1), 0));
                    exp_q.push_back(ev(1, fb, cb, fv, cv, int'(c == nc - 1), int'(c == 0)));
                    if (c == nc - 1) exp_q.push_back(ev(2, fb, cb, fv, cv, 1, 0));
                end
            end
        end
        exp_q.push_back(ev(3, 0, 0, 0, 0, 0, 0));
    endtask

    // Monitor / compare process
    int n_wls = 0, n_comp = 0, n_wb = 0, n_acc = 0, n_done = 0;
    int first_wls_cyc = -1, done_cyc = -1, fall_cyc = -1;
    int last_cmp_fb = 0, last_cmp_cb = 0, last_cmp_fv = 0, last_cmp_cv = 0, last_cmp_last = 0;
    int last_wb_fb = 0;
    bit prev_busy = 1'b0;

    initial begin
        int npulse, kind;
        logic [35:0] obs, exp;
        forever begin
            @(negedge clk);
            if (req_id != built_id) begin
                build_model(req_nf, req_ic);
                built_id = req_id;
                first_wls_cyc = -1;
            end
            if (rst_n) begin
                npulse = int'(wgt_load_start) + int'(compute_start) + int'(wb_start) + int'(done_layer);
                if (npulse > 0) begin
                    check("single_pulse", 64'(npulse), 64'd1);
                    kind = wgt_load_start ? 0 : compute_start ? 1 : wb_start ? 2 : 3;
                    obs = (kind == 3) ? ev(3, 0, 0, 0, 0, 0, 0)
                        : ev(kind, int'(filter_base), int'(channel_base), int'(filt_valid),
                             int'(ch_valid), int'(last_chunk), int'(acc_clear));
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pulse: got %0h expected none (cycle %0d)", obs, cyc);
                    end else begin
                        exp = exp_q.pop_front();
                        check("cmd_event", obs, exp);
                    end
                    case (kind)
                        0: begin
                            n_wls++;
                            if (first_wls_cyc < 0) first_wls_cyc = cyc;
                        end
                        1: begin
                            n_comp++;
                            n_acc += int'(acc_clear);
                            last_cmp_fb = int'(filter_base);
                            last_cmp_cb = int'(channel_base);
                            last_cmp_fv = int'(filt_valid);
                            last_cmp_cv = int'(ch_valid);
                            last_cmp_last = int'(last_chunk);
                        end
                        2: begin
                            n_wb++;
                            last_wb_fb = int'(filter_base);
                        end
                        default: begin
                            n_done++;
                            done_cyc = cyc;
                        end
                    endcase
                end
                if (prev_busy && !busy) fall_cyc = cyc;
            end
            prev_busy = busy;
        end
    end

    // Downstream responders: each done pulse follows its start after rsp_lat cycles.
    int wbd_cyc = -1;
    initial begin
        int wc, cc, bc, inj_ack;
        wc = 0; cc = 0; bc = 0; inj_ack = 0;
        wgt_load_done = 1'b0; compute_done = 1'b0; wb_done = 1'b0;
        forever begin
            @(negedge clk);
            wgt_load_done = 1'b0; compute_done = 1'b0; wb_done = 1'b0;
            if (!rst_n) begin
                wc = 0; cc = 0; bc = 0;
            end else begin
                if (wc > 0) begin wc--; if (wc == 0) wgt_load_done = 1'b1; end
                if (cc > 0) begin cc--; if (cc == 0) compute_done = 1'b1; end
                if (bc > 0) begin
                    bc--;
                    if (bc == 0) begin wb_done = 1'b1; wbd_cyc = cyc; end
                end
                if (wgt_load_start) wc = rsp_lat;
                if (compute_start)  cc = rsp_lat;
                if (wb_start)       bc = rsp_lat;
                if (inj_req != inj_ack) begin compute_done = 1'b1; inj_ack = inj_req; end
            end
        end
    end

    function automatic logic [63:0] all_outs();
        all_outs = 64'({wgt_load_start, compute_start, wb_start, filter_base, channel_base,
                        filt_valid, ch_valid, acc_clear, last_chunk, kernel_size_q, busy, done_layer});
    endfunction

    task automatic run_layer(input int nf, input int ic, input int ks, input int lat,
                             input bit spur, input bit poke);
        int b_wls, b_comp, b_wb, b_done, s_cyc, passes, groups;
        bit zero;
        zero   = (nf == 0 || ic == 0);
        groups = zero ? 0 : (nf + 15) / 16;
        passes = zero ? 0 : groups * ((ic + 15) / 16);
        req_nf = nf; req_ic = ic; rsp_lat = lat; req_id++;
        @(negedge clk);
        b_wls = n_wls; b_comp = n_comp; b_wb = n_wb; b_done = n_done;
        num_filter = 11'(nf); ifm_channel = 11'(ic); kernel_size = 2'(ks);
        start_layer = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start_layer = 1'b0;
        if (spur) begin
            @(negedge clk);
            inj_req++;
        end
        if (poke) begin
            repeat (2) @(negedge clk);
            num_filter = 11'd1; ifm_channel = 11'd1; kernel_size = 2'(ks) ^ 2'b11;
            start_layer = 1'b1;
            @(negedge clk);
            start_layer = 1'b0;
        end
        for (int i = 0; i < 20000 && n_done == b_done; i++) @(negedge clk);
        if (n_done == b_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL layer_timeout: nf=%0d ic=%0d no done_layer", nf, ic);
        end
        repeat (3) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("wls_count",  64'(n_wls - b_wls),   64'(passes));
        check("comp_count", 64'(n_comp - b_comp), 64'(passes));
        check("wb_count",   64'(n_wb - b_wb),     64'(groups));
        check("ksize_q", 64'(kernel_size_q), 64'(ks));
        check("busy_after", 64'(busy), 64'd0);
        if (zero) begin
            check("zero_done_lat", 64'(done_cyc), 64'(s_cyc + 2));
            check("zero_busy_fall", 64'(fall_cyc), 64'(s_cyc + 2));
        end else begin
            check("first_wls_lat", 64'(first_wls_cyc), 64'(s_cyc + 1));
            check("done_after_wbd", 64'(done_cyc), 64'(wbd_cyc + 1));
            check("busy_fall", 64'(fall_cyc), 64'(wbd_cyc + 2));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "global timeout");
    end

    initial begin
        int b_comp, b_acc, b_done;
        rst_n = 1'b0; start_layer = 1'b0;
        ifm_channel = '0; num_filter = '0; kernel_size = '0;
        repeat (3) @(negedge clk);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_outs", all_outs(), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outs", all_outs(), 64'd0);

        // Single pass
        b_comp = n_comp; b_acc = n_acc;
        run_layer(16, 3, 1, 1, 1'b0, 1'b0);
        check("sp_acc", 64'(n_acc - b_acc), 64'd1);
        check("sp_cv", 64'(last_cmp_cv), 64'd3);
        check("sp_fv", 64'(last_cmp_fv), 64'd16);
        check("sp_last", 64'(last_cmp_last), 64'd1);

        // Two filter groups, one channel chunk
        b_acc = n_acc;
        run_layer(32, 16, 3, 2, 1'b0, 1'b0);
        check("tg_acc", 64'(n_acc - b_acc), 64'd2);
        check("tg_wb_fb", 64'(last_wb_fb), 64'd16);

        // Large layer
        b_comp = n_comp; b_acc = n_acc;
        run_layer(255, 512, 3, 1, 1'b0, 1'b0);
        check("lg_comp", 64'(n_comp - b_comp), 64'd512);
        check("lg_acc", 64'(n_acc - b_acc), 64'd16);
        check("lg_fb", 64'(last_cmp_fb), 64'd240);
        check("lg_fv", 64'(last_cmp_fv), 64'd15);
        check("lg_cb", 64'(last_cmp_cb), 64'd496);
        check("lg_wb_fb", 64'(last_wb_fb), 64'd240);

        // Zero-count layers
        run_layer(0, 40, 1, 1, 1'b0, 1'b0);
        run_layer(20, 0, 3, 1, 1'b0, 1'b0);

        // Spurious compute_done in WAIT_W and start_layer while busy
        b_comp = n_comp;
        run_layer(40, 40, 3, 3, 1'b1, 1'b1);
        check("rb_comp", 64'(n_comp - b_comp), 64'd9);

        // Reset during WAIT_C aborts without done_layer
        b_done = n_done;
        req_nf = 32; req_ic = 48; rsp_lat = 3; req_id++;
        @(negedge clk);
        num_filter = 11'd32; ifm_channel = 11'd48; kernel_size = 2'd3;
        start_layer = 1'b1;
        @(negedge clk);
        start_layer = 1'b0;
        for (int i = 0; i < 50 && !compute_start; i++) @(negedge clk);
        check("cmp_before_rst", 64'(compute_start), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_state", 64'(dbg_state), 64'd0);
        check("abort_outs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", 64'(n_done - b_done), 64'd0);
        b_comp = n_comp;
        run_layer(32, 48, 1, 1, 1'b0, 1'b0);
        check("rerun_comp", 64'(n_comp - b_comp), 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
